// File: rtl/bsg_fsb_node_boot_master.sv
// FSB boot master: walks every target node through reset-on, reset-off,
// a settle interval and enable by issuing FSB switch-command packets.
module bsg_fsb_node_boot_master #(
  parameter int width_p       = 80,
  parameter int id_width_p    = 4,
  parameter int nodes_p       = 4,
  parameter logic [nodes_p-1:0] node_mask_p = {nodes_p{1'b1}},
  parameter int hold_cycles_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic               busy_o,
  output logic               done_o
);

  // Counter widths never drop to zero, even for a single node or no hold.
  localparam int CNT_W  = (nodes_p > 1) ? $clog2(nodes_p) : 1;
  localparam int WAIT_W = (hold_cycles_p > 0) ? $clog2(hold_cycles_p + 1) : 1;
  // Mask widened to the full counter range so indexing stays in bounds.
  localparam int MASK_W = 2 ** CNT_W;
  localparam logic [MASK_W-1:0] MASK_EXT = MASK_W'(node_mask_p);

  localparam logic [3:0] OP_RST_ON  = 4'h1;
  localparam logic [3:0] OP_RST_OFF = 4'h2;
  localparam logic [3:0] OP_ENABLE  = 4'h3;

  typedef enum logic [2:0] {
    S_IDLE, S_RST_ON, S_RST_OFF, S_WAIT, S_EN, S_DONE
  } state_e;

  state_e              r_state, w_state_n;
  logic [CNT_W-1:0]    r_node,  w_node_n;
  logic [WAIT_W-1:0]   r_wait,  w_wait_n;
  logic                w_send;
  logic                w_mask_bit;
  logic                w_last;
  logic                w_adv;
  logic                w_v;
  logic [3:0]          w_op;
  logic [width_p-1:0]  w_data;

  assign w_mask_bit = MASK_EXT[r_node];
  assign w_last     = (r_node == CNT_W'(nodes_p - 1));
  assign w_v        = w_send & w_mask_bit;
  // A masked-out slot advances unconditionally; an unmasked one waits for yumi.
  assign w_adv      = w_send & (~w_mask_bit | yumi_i);

  // State, node counter and wait counter registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_node  <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_n;
      r_node  <= w_node_n;
      r_wait  <= w_wait_n;
    end
  end

  // Next-state logic and per-state opcode selection.
  always_comb begin
    w_state_n = r_state;
    w_node_n  = r_node;
    w_wait_n  = r_wait;
    w_send    = 1'b0;
    w_op      = 4'h0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          w_state_n = S_RST_ON;
          w_node_n  = '0;
          w_wait_n  = '0;
        end
      end
      S_RST_ON: begin
        w_send = 1'b1;
        w_op   = OP_RST_ON;
        if (w_adv) begin
          w_node_n = w_last ? '0 : r_node + CNT_W'(1);
          if (w_last) w_state_n = S_RST_OFF;
        end
      end
      S_RST_OFF: begin
        w_send = 1'b1;
        w_op   = OP_RST_OFF;
        if (w_adv) begin
          w_node_n = w_last ? '0 : r_node + CNT_W'(1);
          if (w_last) w_state_n = (hold_cycles_p == 0) ? S_EN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (hold_cycles_p == 0 || r_wait == WAIT_W'(hold_cycles_p - 1)) begin
          w_state_n = S_EN;
          w_wait_n  = '0;
        end else begin
          w_wait_n  = r_wait + WAIT_W'(1);
        end
      end
      S_EN: begin
        w_send = 1'b1;
        w_op   = OP_ENABLE;
        if (w_adv) begin
          w_node_n = w_last ? '0 : r_node + CNT_W'(1);
          if (w_last) w_state_n = S_DONE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Packet assembly; all-zero whenever nothing is offered.
  always_comb begin
    w_data = '0;
    if (w_v) begin
      w_data[width_p-1 -: id_width_p]  = id_width_p'(r_node);
      w_data[width_p-1-id_width_p]     = 1'b1;
      w_data[3:0]                      = w_op;
    end
  end

  assign v_o    = w_v;
  assign data_o = w_data;
  assign busy_o = (r_state == S_RST_ON) || (r_state == S_RST_OFF) ||
                  (r_state == S_WAIT)   || (r_state == S_EN);
  assign done_o = (r_state == S_DONE);

  // Consumer must only accept a packet that is actually offered.
  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!(yumi_i && !w_v));
  end

endmodule
